// File: rtl/display_layer_ctrl.sv
// Frame-synchronous screen-mode FSM that drives the object mux layer-enable mask,
// the game freeze and the death-blink effect; all outputs change only at frame start.
module display_layer_ctrl #(
    parameter int BLINK_FRAMES = 8,
    parameter int DYING_FRAMES = 64
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       buttonPressed,
    input  logic       playerDied,
    input  logic       playerWon,
    input  logic [2:0] livesLeft,
    output logic [9:0] layerEnable,
    output logic       freezeN,
    output logic [2:0] gameState
);

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        PLAY      = 3'd1,
        DYING     = 3'd2,
        DIED_WAIT = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    state_t     state, nextState;
    logic [7:0] frameCnt, nextCnt;
    logic       pendBtn, pendDie, pendWin;
    logic       btnArmed;
    logic       btnEdge, btnEv, dieEv, winEv;

    function automatic logic [9:0] maskFor(input state_t s, input logic [7:0] cnt);
        int phase;
        phase = int'(cnt) / BLINK_FRAMES;
        case (s)
            TITLE:     maskFor = 10'h200;
            PLAY:      maskFor = 10'h03F;
            DYING:     maskFor = phase[0] ? 10'h01F : 10'h03F;
            DIED_WAIT: maskFor = 10'h31F;
            GAME_OVER: maskFor = 10'h340;
            WIN:       maskFor = 10'h298;
            default:   maskFor = 10'h200;
        endcase
    endfunction

    // btnArmed holds "button was low last cycle"; it resets to 0 so a button
    // already held through reset must be released before it can count again.
    assign btnEdge = buttonPressed & btnArmed;
    assign btnEv   = pendBtn | btnEdge;
    assign dieEv   = pendDie | playerDied;
    assign winEv   = pendWin | playerWon;

    always_comb begin
        nextState = state;
        nextCnt   = frameCnt;
        case (state)
            TITLE:     if (btnEv) nextState = PLAY;
            PLAY: begin
                if (winEv)      nextState = WIN;
                else if (dieEv) nextState = DYING;
            end
            DYING: begin
                if (frameCnt == 8'(DYING_FRAMES - 1))
                    nextState = (livesLeft == 3'd0) ? GAME_OVER : DIED_WAIT;
            end
            DIED_WAIT: if (btnEv) nextState = PLAY;
            GAME_OVER: if (btnEv) nextState = TITLE;
            WIN:       if (btnEv) nextState = TITLE;
            default:   nextState = TITLE;
        endcase

        if (nextState != state)
            nextCnt = 8'd0;
        else if (state == DYING)
            nextCnt = frameCnt + 8'd1;
        else
            nextCnt = 8'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= TITLE;
            frameCnt    <= 8'd0;
            layerEnable <= 10'h200;
            freezeN     <= 1'b0;
            pendBtn     <= 1'b0;
            pendDie     <= 1'b0;
            pendWin     <= 1'b0;
            btnArmed    <= 1'b0;
        end else begin
            btnArmed <= ~buttonPressed;
            if (startOfFrame) begin
                state       <= nextState;
                frameCnt    <= nextCnt;
                layerEnable <= maskFor(nextState, nextCnt);
                freezeN     <= (nextState == PLAY);
                pendBtn     <= 1'b0;
                pendDie     <= 1'b0;
                pendWin     <= 1'b0;
            end else begin
                pendBtn <= btnEv;
                pendDie <= dieEv;
                pendWin <= winEv;
            end
        end
    end

    assign gameState = state;

endmodule

// File: tb/tb_display_layer_ctrl.sv
// Bench for display_layer_ctrl: vector table, directed frame sequences and
// randomized traffic against a frame-level reference model.
module tb_display_layer_ctrl;

    localparam int BF = 8;
    localparam int DF = 64;
    localparam int FL = 16;

    localparam logic [2:0] S_TITLE = 3'd0, S_PLAY = 3'd1, S_DYING = 3'd2,
                           S_DW = 3'd3, S_GO = 3'd4, S_WIN = 3'd5;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       buttonPressed;
    logic       playerDied;
    logic       playerWon;
    logic [2:0] livesLeft;
    logic [9:0] layerEnable;
    logic       freezeN;
    logic [2:0] gameState;

    display_layer_ctrl #(.BLINK_FRAMES(BF), .DYING_FRAMES(DF)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .buttonPressed(buttonPressed), .playerDied(playerDied), .playerWon(playerWon),
        .livesLeft(livesLeft), .layerEnable(layerEnable), .freezeN(freezeN),
        .gameState(gameState)
    );

    int total = 0;
    int bad = 0;
    bit autochk = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // frame pulse generator: one cycle in every FL
    initial begin
        int fc;
        fc = 0;
        startOfFrame = 0;
        forever begin
            @(negedge clk);
            fc = (fc == FL - 1) ? 0 : fc + 1;
            startOfFrame = (fc == 0);
        end
    end

    // reference model: screen mode, frame index inside DYING, pending events
    logic [2:0] mState;
    logic [9:0] mMask;
    logic       mFreeze;
    bit         qB, qD, qW, lastHigh;
    int         dyN;
    logic [2:0] mNs;
    int         mNn;
    bit         mb, md, mw;

    function automatic logic [9:0] maskOf(input logic [2:0] s, input int n);
        case (s)
            S_TITLE: return 10'h200;
            S_PLAY:  return 10'h03F;
            S_DYING: return 10'h01F | ((((n / BF) % 2) == 0) ? 10'h020 : 10'h000);
            S_DW:    return 10'h31F;
            S_GO:    return 10'h340;
            S_WIN:   return 10'h298;
            default: return 10'h3FF;
        endcase
    endfunction

    always_comb begin
        mb  = qB || (buttonPressed && !lastHigh);
        md  = qD || playerDied;
        mw  = qW || playerWon;
        mNs = mState;
        mNn = dyN;
        case (mState)
            S_TITLE: if (mb) mNs = S_PLAY;
            S_PLAY: begin
                if (mw) mNs = S_WIN;
                else if (md) begin mNs = S_DYING; mNn = 0; end
            end
            S_DYING: begin
                mNn = dyN + 1;
                if (mNn == DF) mNs = (livesLeft == 3'd0) ? S_GO : S_DW;
            end
            S_DW:    if (mb) mNs = S_PLAY;
            S_GO:    if (mb) mNs = S_TITLE;
            S_WIN:   if (mb) mNs = S_TITLE;
            default: mNs = S_TITLE;
        endcase
    end

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mState <= S_TITLE; mMask <= 10'h200; mFreeze <= 1'b0;
            qB <= 0; qD <= 0; qW <= 0; lastHigh <= 1; dyN <= 0;
        end else begin
            lastHigh <= buttonPressed;
            if (startOfFrame) begin
                mState  <= mNs;
                dyN     <= mNn;
                mMask   <= maskOf(mNs, mNn);
                mFreeze <= (mNs == S_PLAY);
                qB <= 0; qD <= 0; qW <= 0;
            end else begin
                qB <= mb; qD <= md; qW <= mw;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (autochk) begin
            chk("model_state", gameState, mState);
            chk("model_mask", layerEnable, mMask);
            chk("model_freeze", freezeN, mFreeze);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic avoidSof();
        while (startOfFrame) tick();
    endtask

    task automatic waitSof();
        int n;
        n = 0;
        while (!startOfFrame && n < 2 * FL) begin
            tick();
            n++;
        end
        if (!startOfFrame) chk("sof_timeout", 0, 1);
        tick();
    endtask

    task automatic pulse(input bit b, input bit d, input bit w);
        avoidSof();
        buttonPressed = b; playerDied = d; playerWon = w;
        tick();
        buttonPressed = 0; playerDied = 0; playerWon = 0;
    endtask

    task automatic chk3(input string nm, input logic [2:0] st, input logic [9:0] m, input bit f);
        chk({nm, "_state"}, gameState, st);
        chk({nm, "_mask"}, layerEnable, m);
        chk({nm, "_freeze"}, freezeN, f);
    endtask

    typedef struct {
        string      nm;
        bit         btn;
        bit         die;
        bit         win;
        logic [2:0] lives;
        logic [2:0] st;
        logic [9:0] msk;
        bit         frz;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [9:0] expM;
        int n;
        tbl[0] = '{"win_beats_die", 1'b0, 1'b1, 1'b1, 3'd2, S_WIN,   10'h298, 1'b0};
        tbl[1] = '{"win_to_title",  1'b1, 1'b0, 1'b0, 3'd2, S_TITLE, 10'h200, 1'b0};
        tbl[2] = '{"title_to_play", 1'b1, 1'b0, 1'b0, 3'd2, S_PLAY,  10'h03F, 1'b1};
        tbl[3] = '{"play_idle_btn", 1'b1, 1'b0, 1'b0, 3'd2, S_PLAY,  10'h03F, 1'b1};
        tbl[4] = '{"play_win",      1'b0, 1'b0, 1'b1, 3'd2, S_WIN,   10'h298, 1'b0};
        tbl[5] = '{"win_btn",       1'b1, 1'b0, 1'b0, 3'd2, S_TITLE, 10'h200, 1'b0};

        resetN = 1; buttonPressed = 0; playerDied = 0; playerWon = 0; livesLeft = 3'd2;
        #2 resetN = 0;
        tick();
        autochk = 1;
        chk3("reset", S_TITLE, 10'h200, 1'b0);
        tick();
        resetN = 1;

        for (int f = 0; f < 3; f++) begin
            waitSof();
            chk3("idle", S_TITLE, 10'h200, 1'b0);
        end

        // button edge mid-frame: nothing moves until the frame boundary
        repeat (5) tick();
        pulse(1, 0, 0);
        n = 0;
        while (!startOfFrame && n < 2 * FL) begin
            chk3("hold_until_sof", S_TITLE, 10'h200, 1'b0);
            tick();
            n++;
        end
        tick();
        chk3("btn_to_play", S_PLAY, 10'h03F, 1'b1);

        for (int i = 0; i < 6; i++) begin
            livesLeft = tbl[i].lives;
            repeat (3) tick();
            pulse(tbl[i].btn, tbl[i].die, tbl[i].win);
            waitSof();
            chk3(tbl[i].nm, tbl[i].st, tbl[i].msk, tbl[i].frz);
        end

        // DYING with lives left: blink pattern, ignored button, exit after DF frames
        pulse(1, 0, 0);
        waitSof();
        chk3("to_play2", S_PLAY, 10'h03F, 1'b1);
        livesLeft = 3'd2;
        pulse(0, 1, 0);
        for (int k = 0; k < DF; k++) begin
            if (k > 0) begin
                if (k == 30) pulse(1, 0, 0);
                waitSof();
            end else begin
                waitSof();
            end
            expM = 10'h01F | ((((k / BF) % 2) == 0) ? 10'h020 : 10'h000);
            chk3($sformatf("dying_f%0d", k), S_DYING, expM, 1'b0);
        end
        waitSof();
        chk3("died_wait", S_DW, 10'h31F, 1'b0);
        pulse(1, 0, 0);
        waitSof();
        chk3("dw_to_play", S_PLAY, 10'h03F, 1'b1);

        // DYING with no lives ends in GAME_OVER
        livesLeft = 3'd0;
        pulse(0, 1, 0);
        for (int k = 0; k < DF; k++) waitSof();
        chk3("dying_last", S_DYING, 10'h01F, 1'b0);
        waitSof();
        chk3("game_over", S_GO, 10'h340, 1'b0);
        pulse(1, 0, 0);
        waitSof();
        chk3("go_to_title", S_TITLE, 10'h200, 1'b0);

        // reset in the middle of DYING with the button held through it
        pulse(1, 0, 0);
        waitSof();
        livesLeft = 3'd1;
        pulse(0, 1, 0);
        for (int k = 0; k < 21; k++) waitSof();
        chk("mid_dying_state", gameState, S_DYING);
        avoidSof();
        buttonPressed = 1;
        repeat (3) tick();
        resetN = 0;
        #1;
        chk3("async_reset", S_TITLE, 10'h200, 1'b0);
        repeat (2) tick();
        resetN = 1;
        for (int f = 0; f < 2; f++) begin
            waitSof();
            chk3("held_btn_ignored", S_TITLE, 10'h200, 1'b0);
        end
        buttonPressed = 0;
        tick();
        pulse(1, 0, 0);
        waitSof();
        chk3("repress_to_play", S_PLAY, 10'h03F, 1'b1);
        pulse(0, 1, 0);
        waitSof();
        chk3("dying_restart", S_DYING, 10'h03F, 1'b0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) buttonPressed = ~buttonPressed;
            playerDied = ($urandom_range(39) == 0);
            playerWon  = ($urandom_range(199) == 0);
            if ($urandom_range(63) == 0) livesLeft = 3'($urandom_range(3));
            if ($urandom_range(1499) == 0) begin
                resetN = 0;
                tick();
                resetN = 1;
            end else begin
                tick();
            end
        end
        playerDied = 0; playerWon = 0;
        tick();
        autochk = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_layer_ctrl.md
# display_layer_ctrl

Frame-synchronous controller for the VGA object mux's per-layer drawing enables. It tracks the game's screen mode (title, play, dying, died, game over, win) and outputs a registered 10-bit layer-enable mask. The mask is ANDed with each object's drawing request in front of the priority mux. All mode and mask changes take effect only at frame boundaries, so a frame never tears mid-scan. It also drives a movement freeze and the bumpy death-blink effect.

## Interface
- BLINK_FRAMES, 8: frames per half-period of the bumpy blink during DYING (1..127).
- DYING_FRAMES, 64: total frames spent in DYING (2..255).
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- buttonPressed  in  1  level from the keyboard/button decoder; the block detects the rising edge internally.
- playerDied  in  1  one-cycle event from collision logic.
- playerWon  in  1  one-cycle event from collision logic.
- livesLeft  in  3  remaining lives, sampled at the DYING exit.
- layerEnable  out  10  per-layer enables:
  - bit0 prize, bit1 step, bit2 stopwatch, bit3 lifeCounter, bit4 prizeCounter
  - bit5 bumpy, bit6 die, bit7 win, bit8 diedText, bit9 button
- freezeN  out  1  1 = motion/timers may advance; 0 = game frozen.
- gameState  out  3  TITLE=0, PLAY=1, DYING=2, DIED_WAIT=3, GAME_OVER=4, WIN=5.

## Operation
- Event latching, checked every clk:
  - buttonPressed rising edge (compared against the previous-cycle register) sets pendBtn.
  - playerDied sets pendDie; playerWon sets pendWin.
  - Pending flags are sticky until the next startOfFrame edge, then cleared unconditionally.
  - Flags not consumed by the current state are discarded.
- On a startOfFrame cycle the pending flags are evaluated together with any event arriving in that same cycle.
- State transitions, evaluated only when startOfFrame=1:
  - TITLE: btn -> PLAY.
  - PLAY: win -> WIN; else die -> DYING. Win has priority over a simultaneous die.
  - DYING: frameCnt counts frames. At the evaluation where frameCnt==DYING_FRAMES-1: livesLeft==0 -> GAME_OVER, else -> DIED_WAIT. Button is ignored.
  - DIED_WAIT: btn -> PLAY.
  - GAME_OVER: btn -> TITLE.
  - WIN: btn -> TITLE.
- frameCnt (8 bit):
  - Cleared on every state change.
  - Incremented once per startOfFrame while in DYING.
  - Held at 0 in all other states.
- Masks, by state entered or held:
  - TITLE: 0x200 (button only).
  - PLAY: 0x03F.
  - DYING: 0x01F plus bit5 = ~((frameCnt/BLINK_FRAMES) & 1), so bumpy is visible for the first BLINK_FRAMES frames.
  - DIED_WAIT: 0x31F (play layers without bumpy, plus diedText and button).
  - GAME_OVER: 0x340.
  - WIN: 0x298.
- freezeN = 1 only in PLAY.
- Mask, freezeN and gameState are registered together from the next-state value, so they are always mutually consistent.

## Timing
- Reset values:
  - gameState=TITLE, layerEnable=0x200, freezeN=0.
  - frameCnt=0, pending flags=0, button edge register=0.
- Registered outputs update only on a clk edge where startOfFrame=1. They are valid from the next cycle and held constant for the whole frame.
- An event arriving in cycle N is acted on at the first startOfFrame edge at or after N. Latency is 0 to 1 frame; there is no other latency.
- Blink mask bit5 in DYING is computed from the post-increment frameCnt, so it is consistent within a frame.
- DYING lasts exactly DYING_FRAMES frames: entry boundary included, exit boundary excluded.
- A button held continuously generates only one edge. A second transition needs a release and a re-press.
- resetN asserted mid-frame or mid-DYING: immediate asynchronous return to the reset values. The first startOfFrame after release is evaluated normally.
- startOfFrame with no pending events: state holds; only frameCnt and the DYING mask change.

## Test plan
- Reset, then 3 frames with no events -> gameState=0, layerEnable=0x200, freezeN=0 throughout.
- Button rising edge mid-frame -> outputs unchanged until the next startOfFrame. Cycle after that edge: gameState=1, layerEnable=0x03F, freezeN=1.
- playerDied and playerWon in the same cycle while in PLAY -> next frame gameState=5, layerEnable=0x298.
- PLAY, playerDied, livesLeft=2, BLINK_FRAMES=8, DYING_FRAMES=64:
  - bit5 is 1 for frames 0-7, 0 for 8-15, and so on.
  - Exactly 64 frames later: gameState=3, layerEnable=0x31F.
  - Button press during DYING is ignored.
- Same scenario with livesLeft=0 -> GAME_OVER, layerEnable=0x340. Button press then gives TITLE, 0x200.
- resetN pulsed low mid-DYING (frameCnt=20) -> immediately gameState=0, layerEnable=0x200, frameCnt=0. Held button after release gives no transition until it is released and pressed again.
